// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU control / RV32M sequencer.
//   - ALU operation codes driven onto alu_ctrl
//   - alu_op encodings from the main decoder
//   - func3 encodings of the M extension
//   - md_state_t, the multiply/divide sequencer state
//   - decode_alu(): base-ISA decode of alu_op/func7bit30/func3
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [1:0] ALU_OP_LDST   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    // Base-ISA decode. I-type shares the R-type table but never subtracts;
    // bit30 only matters there for the srl/sra choice.
    function automatic logic [3:0] decode_alu(input logic [1:0] alu_op,
                                              input logic       bit30,
                                              input logic [2:0] func3);
        logic [3:0] key;
        logic [3:0] code;
        if (alu_op == ALU_OP_ITYPE) begin
            key = {(func3 == 3'b101) & bit30, func3};
        end else begin
            key = {bit30, func3};
        end
        case (key)
            4'b0000: code = ALU_ADD;
            4'b1000: code = ALU_SUB;
            4'b0111: code = ALU_AND;
            4'b0110: code = ALU_OR;
            4'b0001: code = ALU_SLL;
            4'b0010: code = ALU_SLT;
            4'b0011: code = ALU_SLTU;
            4'b0100: code = ALU_XOR;
            4'b0101: code = ALU_SRL;
            4'b1101: code = ALU_SRA;
            default: code = ALU_AND;
        endcase
        case (alu_op)
            ALU_OP_LDST:   decode_alu = ALU_ADD;
            ALU_OP_BRANCH: decode_alu = ALU_SUB;
            default:       decode_alu = code;
        endcase
    endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: restoring radix-2 divide datapath on unsigned magnitudes.
// Only present when ALU_CTRL_MEXT_EN is defined.
//   clk, rst_n         clock, synchronous active-low reset
//   start              load dividend/divisor, clear partial remainder
//   step               perform one quotient-bit iteration
//   dividend, divisor  XLEN-bit magnitudes, sampled on start
//   quo_next, rem_next result of the iteration performed at the next step;
//                      after the last step these are the final values
`ifdef ALU_CTRL_MEXT_EN
module md_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;

    // One restoring iteration: shift next dividend bit in, subtract if it fits.
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        if (!diff_s[XLEN]) begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b0};
        end
    end

    // Quotient shifts in from the bottom while the dividend shifts out the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_r <= {XLEN{1'b0}};
            rem_r <= {XLEN{1'b0}};
            dvs_r <= {XLEN{1'b0}};
        end else if (start) begin
            quo_r <= dividend;
            rem_r <= {XLEN{1'b0}};
            dvs_r <= divisor;
        end else if (step) begin
            quo_r <= quo_next;
            rem_r <= rem_next;
        end else begin
            quo_r <= quo_r;
            rem_r <= rem_r;
        end
    end

endmodule
`endif

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decode plus an optional RV32M multi-cycle
// multiply/divide sequencer (built only when ALU_CTRL_MEXT_EN is defined).
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        M-op handshake (in_ready high while idle)
//   alu_op, func7bit30,
//   func7bit25, func3          decoded instruction fields
//   op_a, op_b                 rs1 / rs2 for M ops
//   flush                      abort in-flight M op, suppress its result
//   alu_ctrl, unsigned_signal  zero-latency base-ISA decode
//   md_busy, md_valid,
//   md_result                  sequencer status and held result
module alu_ctrl_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            func7bit30,
    input  logic            func7bit25,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [3:0]      alu_ctrl,
    output logic            unsigned_signal,
    output logic            md_busy,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);
    import alu_pkg::*;

    logic m_op_s;

`ifdef ALU_CTRL_MEXT_EN
    assign m_op_s = (alu_op == ALU_OP_RTYPE) && func7bit25;
`else
    assign m_op_s = 1'b0;
`endif

    // M ops drive add onto the ALU; the execute stage ignores it while stalled.
    always_comb begin
        if (m_op_s) begin
            alu_ctrl = ALU_ADD;
        end else begin
            alu_ctrl = decode_alu(alu_op, func7bit30, func3);
        end
    end

    // sltu/sltiu, plus bltu/bgeu on the branch path.
    assign unsigned_signal = (alu_op[1] && (func3 == 3'b011)) ||
                             ((alu_op == ALU_OP_BRANCH) && (func3[2:1] == 2'b11));

`ifdef ALU_CTRL_MEXT_EN
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_START = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ALL_ZERO  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_r, state_nxt_s;
    logic [CW-1:0]     count_r;
    logic [XLEN-1:0]   op_a_r, op_b_r;
    logic [2:0]        func3_r;
    logic              md_valid_r, valid_nxt_s;
    logic [XLEN-1:0]   md_result_r, result_nxt_s;
    logic              accept_s, div_zero_s, ovf_s;
    logic              a_neg_in_s, b_neg_in_s;
    logic [XLEN-1:0]   a_mag_in_s, b_mag_in_s;
    logic [2*XLEN-1:0] a_ext_s, b_ext_s, prod_s;
    logic              sa_s, sb_s;
    logic [XLEN-1:0]   quo_nxt_s, rem_nxt_s, quo_fix_s, rem_fix_s;

    assign accept_s   = in_valid && (state_r == IDLE) && m_op_s && !flush;
    // Special divide cases are judged on the live operands at the accept edge.
    assign div_zero_s = (op_b == ALL_ZERO);
    assign ovf_s      = !func3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);

    assign a_neg_in_s = !func3[0] && op_a[XLEN-1];
    assign b_neg_in_s = !func3[0] && op_b[XLEN-1];
    assign a_mag_in_s = a_neg_in_s ? (ALL_ZERO - op_a) : op_a;
    assign b_mag_in_s = b_neg_in_s ? (ALL_ZERO - op_b) : op_b;

    md_divider #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept_s),
        .step     (state_r == DIV),
        .dividend (a_mag_in_s),
        .divisor  (b_mag_in_s),
        .quo_next (quo_nxt_s),
        .rem_next (rem_nxt_s)
    );

    // Full-width product of sign- or zero-extended operands; the low 2*XLEN
    // bits are exact for every signedness mix.
    assign a_ext_s = {{XLEN{((func3_r == F3_MULH) || (func3_r == F3_MULHSU)) && op_a_r[XLEN-1]}}, op_a_r};
    assign b_ext_s = {{XLEN{(func3_r == F3_MULH) && op_b_r[XLEN-1]}}, op_b_r};
    assign prod_s  = a_ext_s * b_ext_s;

    // Divide sign fix-up from the captured operands (signed ops have func3[0]=0).
    assign sa_s      = !func3_r[0] && op_a_r[XLEN-1];
    assign sb_s      = !func3_r[0] && op_b_r[XLEN-1];
    assign quo_fix_s = (sa_s ^ sb_s) ? (ALL_ZERO - quo_nxt_s) : quo_nxt_s;
    assign rem_fix_s = sa_s ? (ALL_ZERO - rem_nxt_s) : rem_nxt_s;

    // Sequencer state, operand capture and iteration counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            op_a_r  <= ALL_ZERO;
            op_b_r  <= ALL_ZERO;
            func3_r <= 3'b000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_a_r  <= op_a;
                op_b_r  <= op_b;
                func3_r <= func3;
                count_r <= CNT_START;
            end else if ((state_r == DIV) && (count_r != CNT_ZERO)) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state logic; flush overrides everything including a same-cycle accept.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!accept_s) begin
                        state_nxt_s = IDLE;
                    end else if (!func3[2]) begin
                        state_nxt_s = MUL;
                    end else if (div_zero_s || ovf_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                MUL:     state_nxt_s = DONE;
                DIV: begin
                    if (count_r == CNT_ZERO) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Result selection for the edge that enters DONE.
    always_comb begin
        valid_nxt_s  = 1'b0;
        result_nxt_s = md_result_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && func3[2] && div_zero_s) begin
                        valid_nxt_s  = 1'b1;
                        result_nxt_s = func3[1] ? op_a : ALL_ONES;
                    end else if (accept_s && func3[2] && ovf_s) begin
                        valid_nxt_s  = 1'b1;
                        result_nxt_s = func3[1] ? ALL_ZERO : op_a;
                    end else begin
                        valid_nxt_s = 1'b0;
                    end
                end
                MUL: begin
                    valid_nxt_s  = 1'b1;
                    result_nxt_s = (func3_r == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                end
                DIV: begin
                    if (count_r == CNT_ZERO) begin
                        valid_nxt_s  = 1'b1;
                        result_nxt_s = func3_r[1] ? rem_fix_s : quo_fix_s;
                    end else begin
                        valid_nxt_s = 1'b0;
                    end
                end
                default: valid_nxt_s = 1'b0;
            endcase
        end
    end

    // Registered result pulse and held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_valid_r  <= 1'b0;
            md_result_r <= ALL_ZERO;
        end else begin
            md_valid_r  <= valid_nxt_s;
            md_result_r <= result_nxt_s;
        end
    end

    assign md_valid  = md_valid_r;
    assign md_result = md_result_r;
    assign md_busy   = (state_r != IDLE);
    assign in_ready  = (state_r == IDLE);
`else
    logic unused_s;
    assign unused_s  = ^{clk, rst_n, in_valid, func7bit25, op_a, op_b, flush};
    assign in_ready  = 1'b1;
    assign md_busy   = 1'b0;
    assign md_valid  = 1'b0;
    assign md_result = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_alu_ctrl_md.sv
module tb_alu_ctrl_md;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      alu_op = 2'b00;
    logic            func7bit30 = 1'b0;
    logic            func7bit25 = 1'b0;
    logic [2:0]      func3 = 3'b000;
    logic [XLEN-1:0] op_a = 32'h0;
    logic [XLEN-1:0] op_b = 32'h0;
    logic            flush = 1'b0;
    logic [3:0]      alu_ctrl;
    logic            unsigned_signal;
    logic            md_busy;
    logic            md_valid;
    logic [XLEN-1:0] md_result;

    int checks = 0;
    int errors = 0;
    logic [3:0] r_tab [16];

    alu_ctrl_md #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_op          (alu_op),
        .func7bit30      (func7bit30),
        .func7bit25      (func7bit25),
        .func3           (func3),
        .op_a            (op_a),
        .op_b            (op_b),
        .flush           (flush),
        .alu_ctrl        (alu_ctrl),
        .unsigned_signal (unsigned_signal),
        .md_busy         (md_busy),
        .md_valid        (md_valid),
        .md_result       (md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_code(input logic [1:0] op, input logic b30, input logic [2:0] f);
        logic [3:0] t;
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) begin
            t = r_tab[{1'b0, f}];
            if (f == 3'b101 && b30) t = 4'b1010;
            return t;
        end
        return r_tab[{b30, f}];
    endfunction

`ifdef ALU_CTRL_MEXT_EN
    logic [31:0] exp_q [$];
    logic [31:0] last_exp = 32'h0;

    // Issue one M op, scoreboard its result, then check latency, busy, result, pulse.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int c;
        logic busy_ok;
        logic [31:0] want;
        in_valid = 1'b1; alu_op = 2'b10; func7bit25 = 1'b1; func3 = f3; op_a = a; op_b = b;
        exp_q.push_back(exp);
        last_exp = exp;
        tick();
        in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; func3 = ~f3;
        c = 1;
        busy_ok = 1'b1;
        while (md_valid !== 1'b1 && c <= 60) begin
            if (md_busy !== 1'b1) busy_ok = 1'b0;
            tick();
            c++;
        end
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_busy"}, {31'h0, busy_ok & (md_busy === 1'b1)}, 32'h1);
        want = exp_q.pop_front();
        chk({tag, "_res"}, md_result, want);
        tick();
        chk({tag, "_pulse"}, {md_valid, in_ready}, 2'b01);
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) r_tab[i] = 4'b0000;
        r_tab[0] = 4'b0010;  r_tab[8] = 4'b0110;  r_tab[7] = 4'b0000;
        r_tab[6] = 4'b0001;  r_tab[1] = 4'b0011;  r_tab[2] = 4'b0100;
        r_tab[3] = 4'b0101;  r_tab[4] = 4'b0111;  r_tab[5] = 4'b1000;
        r_tab[13] = 4'b1010;

        // Reset state
        tick(); tick();
        chk("rst_status", {md_busy, md_valid, in_ready}, 3'b001);
        chk("rst_result", md_result, 32'h0);
        rst_n = 1'b1;
        tick();

        // Base decode sweep
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 8; f++) begin
                for (int b = 0; b < 2; b++) begin
                    alu_op = op[1:0]; func3 = f[2:0]; func7bit30 = b[0]; func7bit25 = 1'b0;
                    #1;
                    chk($sformatf("dec_op%0d_f%0d_b%0d", op, f, b), {28'h0, alu_ctrl},
                        {28'h0, exp_code(op[1:0], b[0], f[2:0])});
                    chk($sformatf("uns_op%0d_f%0d", op, f), {31'h0, unsigned_signal},
                        {31'h0, ((op >= 2) && (f == 3)) || ((op == 1) && (f >= 6))});
                end
            end
        end
        func7bit30 = 1'b0;

`ifdef ALU_CTRL_MEXT_EN
        alu_op = 2'b10; func7bit25 = 1'b1; func3 = 3'b100; func7bit30 = 1'b1; #1;
        chk("mop_ctrl", {28'h0, alu_ctrl}, 32'h2);
        func7bit30 = 1'b0;
        tick();

        run_md("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_md("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2);
        run_md("mul",    3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 2);
        run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
        run_md("div_n7", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_md("rem_n7", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_md("divu_z", 3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_md("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_md("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("remu_z", 3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1);
        run_md("remu",   3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33);
        run_md("divu",   3'b101, 32'hFFFF_FFFF, 32'h0000_000A, 32'h1999_9999, 33);
        run_md("rem_nb", 3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);

        // Flush while the counter reads 10
        in_valid = 1'b1; alu_op = 2'b10; func7bit25 = 1'b1; func3 = 3'b100;
        op_a = 32'd100; op_b = 32'd3;
        tick();
        in_valid = 1'b0;
        repeat (21) tick();
        chk("pre_flush", {md_busy, md_valid}, 2'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {md_busy, in_ready, md_valid}, 3'b010);
        chk("flush_res", md_result, last_exp);
        run_md("after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2);

        // Flush beats a same-cycle accept
        in_valid = 1'b1; func3 = 3'b100; op_a = 32'd9; op_b = 32'd3; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc", {md_busy, md_valid}, 2'b00);
        tick(); tick();
        chk("flush_acc_res", {md_valid, md_result}, {1'b0, last_exp});

        // Reset in the middle of a divide
        in_valid = 1'b1; func3 = 3'b101; op_a = 32'd50; op_b = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_status", {md_busy, md_valid, in_ready}, 3'b001);
        chk("mid_rst_res", md_result, 32'h0);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                tick();
                if (md_valid !== 1'b0) seen = 1'b1;
            end
            chk("mid_rst_nopulse", {31'h0, seen}, 32'h0);
        end
        run_md("post_rst", 3'b000, 32'd7, 32'd6, 32'd42, 2);
`else
        // Without the M extension bit25 is ignored and the sequencer is absent.
        alu_op = 2'b10; func7bit25 = 1'b1; func3 = 3'b000; func7bit30 = 1'b0; #1;
        chk("nomext_add", {28'h0, alu_ctrl}, 32'h2);
        func7bit30 = 1'b1; #1;
        chk("nomext_sub", {28'h0, alu_ctrl}, 32'h6);
        func7bit30 = 1'b0; func3 = 3'b100; #1;
        chk("nomext_xor", {28'h0, alu_ctrl}, 32'h7);
        in_valid = 1'b1; op_a = 32'd5; op_b = 32'd0;
        repeat (3) begin
            tick();
            chk("nomext_status", {md_busy, md_valid, in_ready}, 3'b001);
            chk("nomext_res", md_result, 32'h0);
        end
        in_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
